instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder, the inverse of the instruction field decoder.
- Accepts decoded fields plus a format tag and packs them into a 32-bit instruction word.
- Checks immediate range and alignment for the selected format.
- Emits the word with an auto-incrementing target address for the instruction-memory loader and the self-check bench (encode -> decode round trip).

Parameters:
- ADDR_W, 32, width of the emitted address counter.
- RESET_ADDR, 0, value of out_addr after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept input
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- in_opcode  in  7  opcode
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R only)
- in_imm  in  32  byte-offset immediate, sign-extended value; U takes the full shifted value
- out_valid  out  1  encoded word valid
- out_ready  in  1  sink accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  address of the presented word
- out_err  out  1  encoding error flag for the presented word
- out_err_code  out  2  0 none, 1 bad fmt, 2 imm range, 3 misaligned
- addr_load  in  1  load address counter
- addr_load_val  in  ADDR_W  value loaded into the counter
- err_count  out  8  saturating count of emitted words with out_err=1

Behaviour:
- Reset (async, rst_n low) clears all registers immediately:
  - out_valid=0, out_instr=0, out_err=0, out_err_code=0, err_count=0, out_addr=RESET_ADDR.
  - Both pipeline stages are empty, so in_ready=1 once the pipeline is idle; reset mid-stream discards all in-flight words.
- Pipeline: stage S1 registers the encoded word and error; stage S2 is the output register.
  - Latency: a word accepted at edge N is visible on out_* after edge N+1, i.e. two cycles after in_valid/in_ready first coincide, with no backpressure.
  - Throughput is one word per cycle.
- Handshakes:
  - in_ready = !S1_valid || !S2_valid || out_ready (combinational).
  - S1 advances to S2 whenever S2 is empty or is draining.
  - Output transfer occurs on out_valid && out_ready.
  - out_* stays stable while out_valid=1 && out_ready=0.
  - No words are dropped or reordered; at most 2 words are buffered.
- Encoding (bit positions are the exact inverse of decode):
  - Common fields: [6:0]=opcode for all formats. rd->[11:7] for R/I/U/J; rs1->[19:15] and funct3->[14:12] for R/I/S/B; rs2->[24:20] for R/S/B; funct7->[31:25] for R.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Checks, applied in priority order bad fmt > misaligned > range:
  - Bad fmt: out_instr=0.
  - Misaligned: B or J with imm[0]=1.
  - Range:
    - I/S: imm[31:11] not all equal.
    - B: imm[31:12] not all equal.
    - J: imm[31:20] not all equal.
    - U: imm[11:0]!=0.
    - R: no immediate check.
  - For range or misaligned errors the word is still emitted with truncated fields.
- Address counter:
  - out_addr increments by 4 on each output transfer and wraps modulo 2^ADDR_W.
  - addr_load=1 loads addr_load_val; load wins over a simultaneous transfer increment.
  - The loaded value applies to the word presented in the next cycle.
- err_count increments on each transfer with out_err=1 and saturates at 255.

Test Plan:
- ADDI: fmt=1, op=0x13, rd=1, rs1=2, f3=0, imm=0xFFFFFFFF -> out_instr=0xFFF10093, err=0, out_addr=0, out_valid 2 cycles after acceptance.
- Back-to-back, out_ready=1:
  - SW: fmt=2, op=0x23, rs1=2, rs2=5, f3=2, imm=8 -> 0x00512423 at addr 4.
  - BEQ: fmt=3, op=0x63, imm=-4 -> 0xFE000EE3 at addr 8.
  - JAL: fmt=5, op=0x6F, rd=1, imm=0x800 -> 0x001000EF at addr 0xC.
- Errors, err_count ends at 4:
  - I with imm=0x800 -> code 2.
  - B with imm=3 -> code 3.
  - U with imm=0x12345001 -> code 2.
  - fmt=7 -> code 1, out_instr=0.
- Backpressure: hold out_ready=0, offer 4 words -> exactly 2 accepted, then in_ready=0; release -> the 4 words emerge in order at addrs 0,4,8,C with out_* stable while stalled.
- Counter edges:
  - addr_load with val=0xFFFFFFFC in the same cycle as a transfer -> next word at 0xFFFFFFFC, following word at 0x0.
  - rst_n low mid-stream -> out_valid=0 immediately, out_addr=RESET_ADDR, no stale word after release.
- Round trip: 1000 random legal field sets -> decoding out_instr reproduces every field and immediate exactly.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Stream bundle between a field source and the RV32I instruction encoder.
// The slave modport is the encoder side; master is the field source and word sink.
interface instr_encoder_if #(
    parameter int ADDR_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [1:0]        out_err_code;

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err, out_err_code
    );

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err, out_err_code
    );
endinterface

// File: rtl/instr_encoder.sv
// Two-stage streaming RV32I encoder: packs decoded fields into an instruction
// word, flags format/alignment/range errors and tags each word with its address.
module instr_encoder #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_encoder_if.slave    bus,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_load_val,
    output logic [7:0]        err_count
);
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_FMT   = 2'd1,
        ERR_RANGE = 2'd2,
        ERR_ALIGN = 2'd3
    } err_e;

    fmt_e        fmt;
    logic [31:0] imm;
    logic [31:0] enc_instr;
    err_e        enc_code;
    logic        fmt_bad;
    logic        imm_bad;
    logic        misaligned;

    logic              s1_valid_q, s1_valid_d;
    logic [31:0]       s1_instr_q, s1_instr_d;
    err_e              s1_code_q,  s1_code_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    err_e              out_code_q,  out_code_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        err_count_q, err_count_d;

    logic accept;
    logic s2_adv;
    logic xfer;

    assign fmt = fmt_e'(bus.in_fmt);
    assign imm = bus.in_imm;

    always_comb begin
        enc_instr  = '0;
        fmt_bad    = 1'b0;
        imm_bad    = 1'b0;
        misaligned = 1'b0;
        case (fmt)
            FMT_R: enc_instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                bus.in_rd, bus.in_opcode};
            FMT_I: begin
                enc_instr = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
                imm_bad   = (imm[31:11] != '0) && (imm[31:11] != '1);
            end
            FMT_S: begin
                enc_instr = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                             imm[4:0], bus.in_opcode};
                imm_bad   = (imm[31:11] != '0) && (imm[31:11] != '1);
            end
            FMT_B: begin
                enc_instr  = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                              imm[4:1], imm[11], bus.in_opcode};
                imm_bad    = (imm[31:12] != '0) && (imm[31:12] != '1);
                misaligned = imm[0];
            end
            FMT_U: begin
                enc_instr = {imm[31:12], bus.in_rd, bus.in_opcode};
                imm_bad   = (imm[11:0] != '0);
            end
            FMT_J: begin
                enc_instr  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
                imm_bad    = (imm[31:20] != '0) && (imm[31:20] != '1);
                misaligned = imm[0];
            end
            default: fmt_bad = 1'b1;
        endcase

        if (fmt_bad)         enc_code = ERR_FMT;
        else if (misaligned) enc_code = ERR_ALIGN;
        else if (imm_bad)    enc_code = ERR_RANGE;
        else                 enc_code = ERR_NONE;
    end

    // S1 may refill in the same cycle it hands its word to S2
    assign s2_adv       = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid_q || !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = out_valid_q && bus.out_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_instr_d  = s1_instr_q;
        s1_code_d   = s1_code_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_code_d  = out_code_q;
        addr_d      = addr_q;
        err_count_d = err_count_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_instr_d = enc_instr;
            s1_code_d  = enc_code;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_instr_d = s1_instr_q;
                out_code_d  = s1_code_q;
            end
        end

        if (addr_load)  addr_d = addr_load_val;
        else if (xfer)  addr_d = addr_q + ADDR_W'(4);

        if (xfer && (out_code_q != ERR_NONE) && (err_count_q != 8'hFF))
            err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_instr_q  <= '0;
            s1_code_q   <= ERR_NONE;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_code_q  <= ERR_NONE;
            addr_q      <= RESET_ADDR;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_instr_q  <= s1_instr_d;
            s1_code_q   <= s1_code_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_code_q  <= out_code_d;
            addr_q      <= addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_instr    = out_instr_q;
    assign bus.out_addr     = addr_q;
    assign bus.out_err      = (out_code_q != ERR_NONE);
    assign bus.out_err_code = out_code_q;
    assign err_count        = err_count_q;
endmodule
